// File: rtl/ikbd_acia_pkg.sv
// Shared constants and state types for the IKBD host-side ACIA.
// Status bit positions, control field codes and the receiver/transmitter state enums.
package ikbd_acia_pkg;

    localparam int SR_RDRF = 0;
    localparam int SR_TDRE = 1;
    localparam int SR_FE   = 4;
    localparam int SR_OVRN = 5;
    localparam int SR_IRQ  = 7;

    localparam int CR_RIE = 7;
    localparam logic [1:0] CR_MR  = 2'b11;
    localparam logic [1:0] CR_TIE = 2'b01;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

endpackage

// File: rtl/ikbd_acia_rx.sv
// Serial receiver: 2-flop synchroniser, start/data/stop state machine, LSB-first shifter.
// Emits a one-clock done pulse with the byte and the sampled stop bit.
module ikbd_acia_rx
    import ikbd_acia_pkg::*;
#(
    parameter int CLK_DIV = 256
)
(
    input  logic       clk,
    input  logic       mcu_rst,
    input  logic       enable_i,
    input  logic       rxd_i,
    output logic       done_o,
    output logic [7:0] data_o,
    output logic       stop_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    rx_state_t     rxState_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitCnt_q;
    logic [7:0]    shift_q;
    logic          done_q;
    logic          stop_q;

    // prev_q lets IDLE spot a falling edge on the synchronised line
    always_ff @(posedge clk or posedge mcu_rst) begin
        if (mcu_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge mcu_rst) begin
        if (mcu_rst) begin
            rxState_q <= RX_IDLE;
            cnt_q     <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else if (!enable_i) begin
            rxState_q <= RX_IDLE;
            cnt_q     <= '0;
            bitCnt_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    cnt_q    <= '0;
                    bitCnt_q <= '0;
                    if (prev_q && !sync2_q) begin
                        rxState_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        rxState_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        shift_q  <= {sync2_q, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == 3'd7) begin
                            rxState_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        done_q    <= 1'b1;
                        stop_q    <= sync2_q;
                        rxState_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    assign done_o = done_q;
    assign data_o = shift_q;
    assign stop_o = stop_q;

endmodule

// File: rtl/ikbd_host_acia.sv
// Host-side 6850-style ACIA for the IKBD link: register file, transmitter, receiver instance.
// Fixed 8N1 framing at CLK_DIV clocks per bit.
module ikbd_host_acia
    import ikbd_acia_pkg::*;
#(
    parameter int CLK_DIV = 256
)
(
    input  logic       clk,
    input  logic       mcu_rst,
    input  logic       cs,
    input  logic       rw,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       rxd,
    output logic       txd
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [7:0] cr_q, cr_d;
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] rdr_q, rdr_d;
    logic       tdre_q, tdre_d;
    logic       rdrf_q, rdrf_d;
    logic       ovrn_q, ovrn_d;
    logic       fe_q, fe_d;

    tx_state_t     txState_q;
    logic [CW-1:0] txCnt_q;
    logic [3:0]    txBit_q;
    logic [8:0]    txShift_q;
    logic          txd_q;

    logic       masterReset;
    logic       wrCtrl;
    logic       wrData;
    logic       rdData;
    logic       txLoad;
    logic       rxDone;
    logic [7:0] rxData;
    logic       rxStop;
    logic [7:0] status;
    logic       unusedCrBits;

    assign masterReset  = (cr_q[1:0] == CR_MR);
    assign wrCtrl       = cs & ~rw & ~rs;
    assign wrData       = cs & ~rw & rs;
    assign rdData       = cs & rw & rs;
    assign unusedCrBits = ^cr_q[4:2];

    // A queued byte loads either from idle or on the edge that ends the stop bit
    assign txLoad = !masterReset && !tdre_q &&
                    ((txState_q == TX_IDLE) ||
                     (txCnt_q == CNT_LAST && txBit_q == 4'd9));

    ikbd_acia_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk      (clk),
        .mcu_rst  (mcu_rst),
        .enable_i (!masterReset),
        .rxd_i    (rxd),
        .done_o   (rxDone),
        .data_o   (rxData),
        .stop_o   (rxStop)
    );

    always_comb begin
        cr_d   = cr_q;
        tdr_d  = tdr_q;
        rdr_d  = rdr_q;
        tdre_d = tdre_q;
        rdrf_d = rdrf_q;
        ovrn_d = ovrn_q;
        fe_d   = fe_q;
        if (wrCtrl) begin
            cr_d = din;
        end
        if (txLoad) begin
            tdre_d = 1'b1;
        end
        if (wrData && !masterReset) begin
            tdr_d  = din;
            tdre_d = 1'b0;
        end
        if (rdData) begin
            rdrf_d = 1'b0;
            ovrn_d = 1'b0;
            fe_d   = 1'b0;
        end
        // A completion landing on the same edge as an RDR read takes precedence
        if (rxDone) begin
            if (!rdrf_q || rdData) begin
                rdr_d  = rxData;
                rdrf_d = 1'b1;
                fe_d   = ~rxStop;
                ovrn_d = ovrn_q;
            end else begin
                ovrn_d = 1'b1;
            end
        end
        if (masterReset) begin
            rdrf_d = 1'b0;
            ovrn_d = 1'b0;
            fe_d   = 1'b0;
            tdre_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge mcu_rst) begin
        if (mcu_rst) begin
            cr_q   <= 8'h00;
            tdr_q  <= 8'h00;
            rdr_q  <= 8'h00;
            tdre_q <= 1'b1;
            rdrf_q <= 1'b0;
            ovrn_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            cr_q   <= cr_d;
            tdr_q  <= tdr_d;
            rdr_q  <= rdr_d;
            tdre_q <= tdre_d;
            rdrf_q <= rdrf_d;
            ovrn_q <= ovrn_d;
            fe_q   <= fe_d;
        end
    end

    always_ff @(posedge clk or posedge mcu_rst) begin
        if (mcu_rst) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= 9'h1FF;
            txd_q     <= 1'b1;
        end else if (masterReset) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= 9'h1FF;
            txd_q     <= 1'b1;
        end else if (txLoad) begin
            txState_q <= TX_SHIFT;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= {1'b1, tdr_q};
            txd_q     <= 1'b0;
        end else if (txState_q == TX_SHIFT) begin
            if (txCnt_q == CNT_LAST) begin
                txCnt_q <= '0;
                if (txBit_q == 4'd9) begin
                    txState_q <= TX_IDLE;
                    txd_q     <= 1'b1;
                end else begin
                    txd_q     <= txShift_q[0];
                    txShift_q <= {1'b1, txShift_q[8:1]};
                    txBit_q   <= txBit_q + 1'b1;
                end
            end else begin
                txCnt_q <= txCnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        irq = (cr_q[CR_RIE] & (rdrf_q | ovrn_q)) |
              ((cr_q[6:5] == CR_TIE) & tdre_q);
        status          = 8'h00;
        status[SR_IRQ]  = irq;
        status[SR_OVRN] = ovrn_q;
        status[SR_FE]   = fe_q;
        status[SR_TDRE] = tdre_q;
        status[SR_RDRF] = rdrf_q;
        dout = rs ? rdr_q : status;
    end

    assign txd = txd_q;

endmodule
